count_check_cw16: RTL and testbench

Stream checker and de-framer that consumes beats tagged with a 16-bit down-count and a final-count flag (count runs cnt_limit down to 0, final flag set when count is 0). It sits downstream of the channelizer's count/alignment stage. It acquires lock on a frame boundary, then verifies every subsequent tag against a locally generated expected count. It forwards verified data with an AXI-Stream tlast on the final beat of each frame, and drops and reports out-of-sequence beats.

---
 rtl/count_check_cw16.sv | 121 ++++++++++++
 tb/tb_count_check_cw16.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_check_cw16.sv
// count_check_cw16: locks onto count-tagged frames, forwards verified beats with tlast and flags out-of-sequence beats.
// Define COUNT_CHECK_ERR_CNT_EN to build the saturating err_count register; otherwise err_count is tied to 0.
module count_check_cw16 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [15:0]           cnt_limit,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [15:0]           s_axis_count,
    input  logic                  s_axis_final_cnt,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  locked,
    output logic                  seq_err,
    output logic [15:0]           err_count
);
    typedef enum logic {SEARCH, LOCK} state_t;
    state_t state_q, state_d;
    logic [15:0] exp_cnt_q, exp_cnt_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic tready_q, tready_d, seq_err_q, seq_err_d;
    logic acc, tag_ok, pass, fail, out_free;
    assign acc      = s_axis_tvalid & tready_q;
    assign tag_ok   = (s_axis_count == exp_cnt_q) && (s_axis_final_cnt == (s_axis_count == 16'd0));
    assign pass     = acc && (state_q == LOCK) && tag_ok;
    assign fail     = acc && (state_q == LOCK) && !tag_ok;
    assign out_free = ~out_valid_q | m_axis_tready;
    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        if (state_q == SEARCH) begin
            if (acc && s_axis_final_cnt && (s_axis_count == 16'd0)) begin
                state_d   = LOCK;
                exp_cnt_d = cnt_limit;
            end
        end else if (pass) begin
            exp_cnt_d = (exp_cnt_q == 16'd0) ? cnt_limit : exp_cnt_q - 16'd1;
        end else if (fail) begin
            state_d = SEARCH;
        end
    end
    // Skid is only ever full while tready is low, so it never coincides with a new pass.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = pass;
                if (pass) begin
                    out_data_d = s_axis_tdata;
                    out_last_d = s_axis_final_cnt;
                end
            end
        end else if (pass) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_axis_tdata;
            skid_last_d  = s_axis_final_cnt;
        end
    end
    assign tready_d  = ~skid_valid_d;
    assign seq_err_d = fail;
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q      <= SEARCH;
            exp_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            tready_q     <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_cnt_q    <= exp_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            tready_q     <= tready_d;
            seq_err_q    <= seq_err_d;
        end
    end
    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign locked        = (state_q == LOCK);
    assign seq_err       = seq_err_q;
`ifdef COUNT_CHECK_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge clk) begin
        if (sync_reset)
            err_cnt_q <= '0;
        else if (fail && (err_cnt_q != 16'hFFFF))
            err_cnt_q <= err_cnt_q + 16'd1;
    end
    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_count_check_cw16.sv
// tb_count_check_cw16: directed checks of lock/verify/de-frame behaviour, backpressure and mid-frame reset.
module tb_count_check_cw16;
    logic        clk = 1'b0;
    logic        sync_reset = 1'b1;
    logic [15:0] cnt_limit = 16'd3;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic [15:0] s_axis_count = '0;
    logic        s_axis_final_cnt = 1'b0;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        locked;
    logic        seq_err;
    logic [15:0] err_count;
`ifdef COUNT_CHECK_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    int n_asserts = 0;
    int n_fail = 0;
    int acc_n, cyc;
    logic [15:0] c;
    logic [32:0] q[$];
    logic [32:0] e;

    count_check_cw16 #(.DATA_WIDTH(32)) dut (
        .clk(clk), .sync_reset(sync_reset), .cnt_limit(cnt_limit),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .s_axis_count(s_axis_count), .s_axis_final_cnt(s_axis_final_cnt),
        .s_axis_tready(s_axis_tready), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .locked(locked), .seq_err(seq_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] cnt, input logic fin, input logic [31:0] dat);
        s_axis_tvalid    = 1'b1;
        s_axis_count     = cnt;
        s_axis_final_cnt = fin;
        s_axis_tdata     = dat;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] dat, input logic last);
        chk({tag, "_tvalid"}, m_axis_tvalid, 1);
        chk({tag, "_tdata"}, m_axis_tdata, dat);
        chk({tag, "_tlast"}, m_axis_tlast, last);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_locked", locked, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_err_count", err_count, 0);
        sync_reset = 1'b0;
        tick();
        chk("rst_tready_after", s_axis_tready, 1);

        // Acquire lock, then one full frame of 4
        beat(16'd2, 1'b0, 32'hA000_0002);
        chk("srch2_tvalid", m_axis_tvalid, 0);
        chk("srch2_locked", locked, 0);
        beat(16'd1, 1'b0, 32'hA000_0001);
        chk("srch1_tvalid", m_axis_tvalid, 0);
        beat(16'd0, 1'b1, 32'hA000_0000);
        chk("lock_locked", locked, 1);
        chk("lock_tvalid", m_axis_tvalid, 0);
        chk("lock_seq_err", seq_err, 0);
        beat(16'd3, 1'b0, 32'hB000_0003);
        chk_out("f1_c3", 32'hB000_0003, 0);
        chk("f1_c3_seq_err", seq_err, 0);
        beat(16'd2, 1'b0, 32'hB000_0002);
        chk_out("f1_c2", 32'hB000_0002, 0);
        beat(16'd1, 1'b0, 32'hB000_0001);
        chk_out("f1_c1", 32'hB000_0001, 0);
        beat(16'd0, 1'b1, 32'hB000_0000);
        chk_out("f1_c0", 32'hB000_0000, 1);
        chk("f1_seq_err", seq_err, 0);
        chk("f1_locked", locked, 1);

        // Wrong count (2 where 3 expected)
        beat(16'd2, 1'b0, 32'hBAD0_0002);
        chk("bad_seq_err", seq_err, 1);
        chk("bad_locked", locked, 0);
        chk("bad_tvalid", m_axis_tvalid, 0);
        chk("bad_err_count", err_count, ERR_EN ? 1 : 0);
        tick();
        chk("bad_seq_err_pulse", seq_err, 0);
        beat(16'd3, 1'b0, 32'hC000_0003);
        chk("resrch_tvalid", m_axis_tvalid, 0);
        chk("resrch_locked", locked, 0);
        beat(16'd0, 1'b1, 32'hC000_0000);
        chk("relock_locked", locked, 1);
        chk("relock_tvalid", m_axis_tvalid, 0);

        // Count 0 with final=0 where 0 is expected
        beat(16'd3, 1'b0, 32'hD000_0003);
        beat(16'd2, 1'b0, 32'hD000_0002);
        beat(16'd1, 1'b0, 32'hD000_0001);
        chk_out("f2_c1", 32'hD000_0001, 0);
        beat(16'd0, 1'b0, 32'hD000_0000);
        chk("nofin_seq_err", seq_err, 1);
        chk("nofin_locked", locked, 0);
        chk("nofin_tvalid", m_axis_tvalid, 0);
        chk("nofin_err_count", err_count, ERR_EN ? 2 : 0);
        beat(16'd0, 1'b1, 32'hD100_0000);
        chk("relock2_locked", locked, 1);
        chk("relock2_seq_err", seq_err, 0);

        // cnt_limit=0 takes effect only at the next reload
        cnt_limit = 16'd0;
        beat(16'd3, 1'b0, 32'hE000_0003);
        chk_out("defer_c3", 32'hE000_0003, 0);
        beat(16'd2, 1'b0, 32'hE000_0002);
        beat(16'd1, 1'b0, 32'hE000_0001);
        beat(16'd0, 1'b1, 32'hE000_0000);
        chk_out("defer_c0", 32'hE000_0000, 1);
        for (int i = 0; i < 5; i++) begin
            beat(16'd0, 1'b1, 32'hE100_0000 + i);
            chk_out("one_beat", 32'hE100_0000 + i, 1);
            chk("one_beat_locked", locked, 1);
        end

        // Backpressure with toggling m_axis_tready and random s_axis_tvalid
        cnt_limit = 16'd3;
        beat(16'd0, 1'b1, 32'hF000_0000);
        chk_out("reload3", 32'hF000_0000, 1);
        tick();
        chk("bp_idle_tvalid", m_axis_tvalid, 0);
        acc_n = 0;
        cyc = 0;
        c = 16'd3;
        while (acc_n < 20 && cyc < 400) begin
            m_axis_tready    = (cyc % 2 == 0);
            s_axis_tvalid    = 1'($urandom_range(0, 1));
            s_axis_count     = c;
            s_axis_final_cnt = (c == 16'd0);
            s_axis_tdata     = 32'h5000_0000 + acc_n;
            chk("bp_tvalid", m_axis_tvalid, q.size() != 0);
            chk("bp_tready", s_axis_tready, q.size() < 2);
            if (m_axis_tvalid && m_axis_tready && q.size() != 0) begin
                e = q.pop_front();
                chk("bp_tdata", m_axis_tdata, e[31:0]);
                chk("bp_tlast", m_axis_tlast, e[32]);
            end
            if (s_axis_tvalid && s_axis_tready) begin
                q.push_back({s_axis_final_cnt, s_axis_tdata});
                acc_n++;
                c = (c == 16'd0) ? 16'd3 : c - 16'd1;
            end
            tick();
            cyc++;
        end
        chk("bp_accepted", acc_n, 20);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 10) begin
            chk("drain_tvalid", m_axis_tvalid, 1);
            if (m_axis_tvalid) begin
                e = q.pop_front();
                chk("drain_tdata", m_axis_tdata, e[31:0]);
                chk("drain_tlast", m_axis_tlast, e[32]);
            end
            tick();
            cyc++;
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_tvalid_end", m_axis_tvalid, 0);
        chk("bp_seq_err", seq_err, 0);
        chk("bp_locked", locked, 1);

        // Fill both registers, then reset mid-frame with output held
        m_axis_tready = 1'b0;
        beat(16'd3, 1'b0, 32'h7000_0003);
        chk("full1_tready", s_axis_tready, 1);
        chk_out("full1", 32'h7000_0003, 0);
        beat(16'd2, 1'b0, 32'h7000_0002);
        chk("full2_tready", s_axis_tready, 0);
        chk_out("full2_hold", 32'h7000_0003, 0);
        beat(16'd1, 1'b0, 32'h7000_0001);
        chk_out("full3_hold", 32'h7000_0003, 0);
        sync_reset = 1'b1;
        tick();
        chk("mrst_tvalid", m_axis_tvalid, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_err_count", err_count, 0);
        chk("mrst_tready", s_axis_tready, 0);
        sync_reset = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        chk("mrst_tready_after", s_axis_tready, 1);
        beat(16'd1, 1'b0, 32'h7100_0001);
        chk("mrst_stale_tvalid", m_axis_tvalid, 0);
        chk("mrst_stale_locked", locked, 0);
        beat(16'd0, 1'b1, 32'h7100_0000);
        chk("mrst_relock", locked, 1);
        chk("mrst_relock_tvalid", m_axis_tvalid, 0);
        beat(16'd3, 1'b0, 32'h7200_0003);
        chk_out("mrst_fwd", 32'h7200_0003, 0);
        chk("end_err_count", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
